// File: rtl/rram_prog_pkg.sv
// Shared types and constants for the 2-RRAM cell programming sequencer.
// Line patterns are packed {bl[2:0], wl[2:0]} for the addressed cell.
package rram_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PULSE_R0,
    GAP0,
    PULSE_R1,
    GAP1,
    VERIFY,
    DONE
  } state_t;

  localparam logic [5:0] PAT_D1_R0 = 6'b100_001;  // r0 -> 1
  localparam logic [5:0] PAT_D1_R1 = 6'b010_100;  // r1 -> 0
  localparam logic [5:0] PAT_D0_R0 = 6'b001_100;  // r0 -> 0
  localparam logic [5:0] PAT_D0_R1 = 6'b100_010;  // r1 -> 1

  localparam int RETRY_LIMIT = 2;

  function automatic logic [5:0] line_pat(state_t s, logic data);
    case (s)
      PULSE_R0: return data ? PAT_D1_R0 : PAT_D0_R0;
      PULSE_R1: return data ? PAT_D1_R1 : PAT_D0_R1;
      default:  return 6'b000_000;
    endcase
  endfunction

endpackage

// File: rtl/rram_prog_timer.sv
// Loadable down-counter shared by all timed states; tc flags the last cycle
// of the current state (count == 1).
module rram_prog_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == W'(1));

endmodule

// File: rtl/rram_prog_ctrl.sv
// Two-pulse RRAM configuration-cell programming sequencer (top level).
// Optional read-back verify with retries is enabled by RRAM_PROG_VERIFY_EN.
module rram_prog_ctrl
  import rram_prog_pkg::*;
#(
  parameter int NUM_CELLS     = 8,
  parameter int ADDR_W        = 3,
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic                   req_data,
  output logic [3*NUM_CELLS-1:0] bl_o,
  output logic [3*NUM_CELLS-1:0] wl_o,
  output logic                   busy,
  output logic                   done,
  output logic                   err
`ifdef RRAM_PROG_VERIFY_EN
  ,
  input  logic [NUM_CELLS-1:0]   cell_dout,
  output logic                   verify_fail
`endif
);

  localparam int MAX_T = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = $clog2(MAX_T + 1);

  state_t                 state_q, state_n;
  logic [ADDR_W-1:0]      addr_q, addr_nx;
  logic                   data_q, data_nx;
  logic                   err_q;
  logic [3*NUM_CELLS-1:0] bl_q, wl_q, bl_n, wl_n;
  logic [5:0]             pat;
  logic                   accept, addr_ok, tc, load;
  logic [CNT_W-1:0]       load_val;

`ifdef RRAM_PROG_VERIFY_EN
  logic [1:0] retry_q;
  logic       fail_q;
  logic       retry_inc, retry_clr, fail_set;
`endif

  assign accept  = req_valid && req_ready;
  assign addr_ok = int'(req_addr) < NUM_CELLS;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state_q;
`ifdef RRAM_PROG_VERIFY_EN
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    fail_set  = 1'b0;
`endif
    case (state_q)
      IDLE: if (accept && addr_ok) begin
        state_n = PULSE_R0;
`ifdef RRAM_PROG_VERIFY_EN
        retry_clr = 1'b1;
`endif
      end
      PULSE_R0: if (tc) state_n = GAP0;
      GAP0:     if (tc) state_n = PULSE_R1;
      PULSE_R1: if (tc) state_n = GAP1;
`ifdef RRAM_PROG_VERIFY_EN
      GAP1:     if (tc) state_n = VERIFY;
      VERIFY: begin
        if (cell_dout[addr_q] == data_q) begin
          state_n = DONE;
        end else if (int'(retry_q) < RETRY_LIMIT) begin
          state_n   = PULSE_R0;
          retry_inc = 1'b1;
        end else begin
          state_n  = DONE;
          fail_set = 1'b1;
        end
      end
`else
      GAP1:     if (tc) state_n = DONE;
`endif
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Every state entry reloads the timer with that state's duration.
  always_comb begin
    load = (state_n != state_q);
    case (state_n)
      PULSE_R0, PULSE_R1: load_val = CNT_W'(PULSE_CYCLES);
      GAP0, GAP1:         load_val = CNT_W'(SETTLE_CYCLES);
      default:            load_val = CNT_W'(1);
    endcase
  end

  rram_prog_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  // Lines are registered from the next state so they switch on the same
  // edge as the state itself, using the request fields on the accept edge.
  always_comb begin
    addr_nx = (state_q == IDLE) ? req_addr : addr_q;
    data_nx = (state_q == IDLE) ? req_data : data_q;
    pat     = line_pat(state_n, data_nx);
    bl_n    = '0;
    wl_n    = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (int'(addr_nx) == i) begin
        bl_n[3*i +: 3] = pat[5:3];
        wl_n[3*i +: 3] = pat[2:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= 1'b0;
      err_q   <= 1'b0;
      bl_q    <= '0;
      wl_q    <= '0;
    end else begin
      state_q <= state_n;
      err_q   <= accept && !addr_ok;
      bl_q    <= bl_n;
      wl_q    <= wl_n;
      if (accept && addr_ok) begin
        addr_q <= req_addr;
        data_q <= req_data;
      end
    end
  end

`ifdef RRAM_PROG_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
      fail_q  <= 1'b0;
    end else if (retry_clr) begin
      retry_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      if (retry_inc) retry_q <= retry_q + 2'd1;
      if (fail_set)  fail_q  <= 1'b1;
    end
  end

  assign verify_fail = (state_q == DONE) && fail_q;
`endif

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign bl_o      = bl_q;
  assign wl_o      = wl_q;

endmodule

// File: tb/tb_rram_prog_ctrl.sv
// Self-checking bench for rram_prog_ctrl: directed and randomized writes
// checked cycle-by-cycle against a timeline model and a 2-RRAM cell model.
module tb_rram_prog_ctrl;

  localparam int NC  = 8;
  localparam int AW  = 4;
  localparam int PC  = 4;
  localparam int SC  = 2;
  localparam int SEQ = 2*PC + 2*SC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_data = 1'b0;
  logic [3*NC-1:0] bl_o, wl_o;
  logic          busy, done, err;

  int total = 0;
  int bad   = 0;
  bit r0 [NC];
  bit r1 [NC];

  rram_prog_ctrl #(
    .NUM_CELLS(NC), .ADDR_W(AW), .PULSE_CYCLES(PC), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .bl_o(bl_o), .wl_o(wl_o),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cells_active();
    int n = 0;
    for (int i = 0; i < NC; i++)
      if (bl_o[3*i +: 3] != 3'b000 || wl_o[3*i +: 3] != 3'b000) n++;
    return n;
  endfunction

  // Physical effect of a pulse on each cell's two resistive elements.
  task automatic cell_update();
    logic [2:0] b, w;
    for (int i = 0; i < NC; i++) begin
      b = bl_o[3*i +: 3];
      w = wl_o[3*i +: 3];
      if (b[2] && w[0]) r0[i] = 1'b1;
      if (b[0] && w[2]) r0[i] = 1'b0;
      if (b[1] && w[2]) r1[i] = 1'b0;
      if (b[2] && w[1]) r1[i] = 1'b1;
    end
  endtask

  // Which bl/wl line of the addressed cell each pulse must drive.
  task automatic exp_pulse(input bit data, input bit second, output int bi, output int wi);
    if (data && !second)      begin bi = 2; wi = 0; end
    else if (data && second)  begin bi = 1; wi = 2; end
    else if (!second)         begin bi = 0; wi = 2; end
    else                      begin bi = 2; wi = 1; end
  endtask

  // Starts at a negedge in IDLE; ends at the negedge of the following IDLE cycle.
  task automatic do_write(input int addr, input bit data, input bit hold,
                          input int naddr, input bit ndata);
    logic [3*NC-1:0] eb, ew;
    int bi, wi;
    bit dv;
    check("ready_before_req", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_addr  = AW'(addr);
    req_data  = data;
    for (int j = 0; j <= SEQ; j++) begin
      @(negedge clk);
      cell_update();
      eb = '0;
      ew = '0;
      if (j < PC) begin
        exp_pulse(data, 1'b0, bi, wi);
        eb[3*addr + bi] = 1'b1;
        ew[3*addr + wi] = 1'b1;
      end else if (j >= PC + SC && j < 2*PC + SC) begin
        exp_pulse(data, 1'b1, bi, wi);
        eb[3*addr + bi] = 1'b1;
        ew[3*addr + wi] = 1'b1;
      end
      check($sformatf("bl a%0d d%0d c%0d", addr, data, j), 64'(bl_o), 64'(eb));
      check($sformatf("wl a%0d d%0d c%0d", addr, data, j), 64'(wl_o), 64'(ew));
      check($sformatf("busy c%0d", j), 64'(busy), 64'(j < SEQ));
      check($sformatf("done c%0d", j), 64'(done), 64'(j == SEQ));
      check($sformatf("ready c%0d", j), 64'(req_ready), 64'(0));
      check($sformatf("err c%0d", j), 64'(err), 64'(0));
      check($sformatf("onehot c%0d", j), 64'(cells_active() <= 1), 64'(1));
      if (hold) begin
        req_valid = 1'b1;
        req_addr  = AW'(naddr);
        req_data  = ndata;
      end else begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom);
        req_data  = 1'($urandom);
      end
    end
    if (!hold) req_valid = 1'b0;
    @(negedge clk);
    dv = r0[addr] | !r1[addr];
    check($sformatf("dout a%0d", addr), 64'(dv), 64'(data));
    check("idle_ready", 64'(req_ready), 64'(1));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_done", 64'(done), 64'(0));
    check("idle_lines", 64'({bl_o, wl_o}), 64'(0));
  endtask

  task automatic do_err(input int addr);
    check("ready_before_bad", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_addr  = AW'(addr);
    req_data  = 1'($urandom);
    @(negedge clk);
    req_valid = 1'b0;
    check($sformatf("err_pulse a%0d", addr), 64'(err), 64'(1));
    check("err_ready", 64'(req_ready), 64'(1));
    check("err_busy", 64'(busy), 64'(0));
    check("err_lines", 64'({bl_o, wl_o}), 64'(0));
    @(negedge clk);
    check("err_clear", 64'(err), 64'(0));
    check("err_no_done", 64'(done), 64'(0));
    check("err_lines2", 64'({bl_o, wl_o}), 64'(0));
    check("err_ready2", 64'(req_ready), 64'(1));
  endtask

  initial begin
    int  a, na;
    bit  d, nd, h;
    for (int i = 0; i < NC; i++) begin
      r0[i] = 1'($urandom);
      r1[i] = 1'($urandom);
    end

    repeat (2) @(negedge clk);
    check("rst_lines", 64'({bl_o, wl_o}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(1));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));

    // Reset in the middle of PULSE_R0 drops the lines without waiting for an edge.
    req_valid = 1'b1;
    req_addr  = AW'(5);
    req_data  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_pulse_bl", 64'(bl_o), 64'(1) << 17);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bl", 64'(bl_o), 64'(0));
    check("mid_rst_wl", 64'(wl_o), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 64'(req_ready), 64'(1));
    check("mid_rst_busy2", 64'(busy), 64'(0));

    do_write(3, 1'b1, 1'b0, 0, 1'b0);
    do_write(0, 1'b0, 1'b0, 0, 1'b0);
    do_err(9);
    do_write(2, 1'b1, 1'b1, 6, 1'b0);
    do_write(6, 1'b0, 1'b0, 0, 1'b0);
    do_write(NC - 1, 1'b1, 1'b0, 0, 1'b0);

    a = $urandom_range(0, NC - 1);
    d = 1'($urandom);
    for (int i = 0; i < 20; i++) begin
      h  = 1'($urandom_range(0, 1));
      na = $urandom_range(0, NC - 1);
      nd = 1'($urandom);
      do_write(a, d, h, na, nd);
      if (h) begin
        a = na;
        d = nd;
      end else begin
        if ($urandom_range(0, 3) == 0) do_err($urandom_range(NC, 15));
        a = $urandom_range(0, NC - 1);
        d = 1'($urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
